// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined I/S/B/J/U immediate generator with pc+imm target and 2-entry skid buffer.
// Optional Z-type (CSR uimm) decode on imm_sel 101 is enabled by defining IMM_ZTYPE_EN.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int PC_REL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      imm_sel,
  input  logic [24:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [31:0]     ins;
  logic [31:0]     imm32;
  logic            new_illegal;
  logic [XLEN-1:0] new_imm;
  logic [XLEN-1:0] new_target;

  // Re-align to instruction bit numbering so the field slices read like the ISA.
  assign ins = {instr, 7'b0};

  always_comb begin
    imm32       = '0;
    new_illegal = 1'b0;
    case (imm_sel)
      3'b000:  imm32 = {{20{ins[31]}}, ins[31:20]};
      3'b001:  imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'b010:  imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      3'b011:  imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b100:  imm32 = {ins[31:12], 12'b0};
`ifdef IMM_ZTYPE_EN
      3'b101:  imm32 = {27'b0, ins[19:15]};
`endif
      default: new_illegal = 1'b1;
    endcase
  end

  // Every 32-bit form is already correctly signed at bit 31, so one extension covers all types.
  if (XLEN == 64) begin : g_x64
    assign new_imm = {{32{imm32[31]}}, imm32};
  end else begin : g_x32
    assign new_imm = imm32;
  end

  if (PC_REL != 0) begin : g_pc_rel
    assign new_target = pc + new_imm;
  end else begin : g_no_pc_rel
    assign new_target = '0;
  end

  logic            o_valid_q, o_valid_d;
  logic [XLEN-1:0] o_imm_q, o_imm_d;
  logic [XLEN-1:0] o_target_q, o_target_d;
  logic            o_illegal_q, o_illegal_d;
  logic            s_valid_q, s_valid_d;
  logic [XLEN-1:0] s_imm_q, s_imm_d;
  logic [XLEN-1:0] s_target_q, s_target_d;
  logic            s_illegal_q, s_illegal_d;
  logic            in_fire;
  logic            o_free;

  assign in_ready = ~s_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign o_free   = ~o_valid_q | out_ready;

  always_comb begin
    o_valid_d   = o_valid_q;
    o_imm_d     = o_imm_q;
    o_target_d  = o_target_q;
    o_illegal_d = o_illegal_q;
    s_valid_d   = s_valid_q;
    s_imm_d     = s_imm_q;
    s_target_d  = s_target_q;
    s_illegal_d = s_illegal_q;
    if (s_valid_q) begin
      if (out_ready) begin
        o_valid_d   = 1'b1;
        o_imm_d     = s_imm_q;
        o_target_d  = s_target_q;
        o_illegal_d = s_illegal_q;
        s_valid_d   = 1'b0;
      end
    end else begin
      if (out_ready) begin
        o_valid_d = 1'b0;
      end
      if (in_fire) begin
        if (o_free) begin
          o_valid_d   = 1'b1;
          o_imm_d     = new_imm;
          o_target_d  = new_target;
          o_illegal_d = new_illegal;
        end else begin
          s_valid_d   = 1'b1;
          s_imm_d     = new_imm;
          s_target_d  = new_target;
          s_illegal_d = new_illegal;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid_q   <= 1'b0;
      o_imm_q     <= '0;
      o_target_q  <= '0;
      o_illegal_q <= 1'b0;
      s_valid_q   <= 1'b0;
      s_imm_q     <= '0;
      s_target_q  <= '0;
      s_illegal_q <= 1'b0;
    end else begin
      o_valid_q   <= o_valid_d;
      o_imm_q     <= o_imm_d;
      o_target_q  <= o_target_d;
      o_illegal_q <= o_illegal_d;
      s_valid_q   <= s_valid_d;
      s_imm_q     <= s_imm_d;
      s_target_q  <= s_target_d;
      s_illegal_q <= s_illegal_d;
    end
  end

  assign out_valid = o_valid_q;
  assign imm       = o_imm_q;
  assign target    = o_target_q;
  assign illegal   = o_illegal_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe (XLEN 32 and 64 instances).
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, illegal;
  logic [2:0]  imm_sel;
  logic [24:0] instr;
  logic [31:0] pc, imm, target;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_illegal;
  logic [2:0]  w_imm_sel;
  logic [24:0] w_instr;
  logic [63:0] w_pc, w_imm, w_target;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .PC_REL(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .instr(instr), .pc(pc), .out_valid(out_valid),
    .out_ready(out_ready), .imm(imm), .target(target), .illegal(illegal)
  );

  imm_gen_pipe #(.XLEN(64), .PC_REL(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .imm_sel(w_imm_sel), .instr(w_instr), .pc(w_pc), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .imm(w_imm), .target(w_target), .illegal(w_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] ins, input logic [31:0] p);
    in_valid = v;
    imm_sel  = sel;
    instr    = ins[31:7];
    pc       = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; drive(1'b1, 3'b000, 32'hFFF00093, 32'h100);
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_imm_sel = 3'b000; w_instr = '0; w_pc = '0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (imm !== 32'h0 || target !== 32'h0 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_data: imm %h target %h illegal %b want 0/0/0", imm, target, illegal); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_basic();
    drive(1'b1, 3'b000, 32'hFFF00093, 32'h100);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    n_checks++; if (out_valid !== 1'b1 || imm !== 32'hFFFF_FFFF || target !== 32'hFF || illegal !== 1'b0) begin
      n_fail++; $display("FAIL basic_i: v %b imm %h tgt %h ill %b want 1/ffffffff/000000ff/0", out_valid, imm, target, illegal); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'b010, 32'hFF9FF06F, 32'h100);
    tick();
    n_checks++; if (out_valid !== 1'b1 || imm !== 32'hFFFF_FFF8 || target !== 32'hF8) begin
      n_fail++; $display("FAIL b2b_j: v %b imm %h tgt %h want 1/fffffff8/000000f8", out_valid, imm, target); end
    drive(1'b1, 3'b100, 32'h123450B7, 32'h100);
    tick();
    n_checks++; if (out_valid !== 1'b1 || imm !== 32'h1234_5000 || target !== 32'h1234_5100) begin
      n_fail++; $display("FAIL b2b_u: v %b imm %h tgt %h want 1/12345000/12345100", out_valid, imm, target); end
    drive(1'b1, 3'b001, 32'hFE112E23, 32'h40);
    tick();
    n_checks++; if (imm !== 32'hFFFF_FFFC || target !== 32'h3C) begin
      n_fail++; $display("FAIL b2b_s: imm %h tgt %h want fffffffc/0000003c", imm, target); end
    drive(1'b1, 3'b011, 32'hFE000EE3, 32'h80);
    tick();
    n_checks++; if (imm !== 32'hFFFF_FFFC || target !== 32'h7C) begin
      n_fail++; $display("FAIL b2b_b: imm %h tgt %h want fffffffc/0000007c", imm, target); end
    drive(1'b1, 3'b000, 32'h00800093, 32'hFFFF_FFFC);
    tick();
    n_checks++; if (imm !== 32'h8 || target !== 32'h4) begin
      n_fail++; $display("FAIL wrap32: imm %h tgt %h want 00000008/00000004", imm, target); end
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h00100093, 32'h0);
    tick();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || imm !== 32'h1) begin
      n_fail++; $display("FAIL bp_first: rdy %b v %b imm %h want 1/1/00000001", in_ready, out_valid, imm); end
    drive(1'b1, 3'b000, 32'h00200093, 32'h0);
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    drive(1'b1, 3'b000, 32'h00300093, 32'h0);
    tick(); tick();
    n_checks++; if (out_valid !== 1'b1 || imm !== 32'h1 || target !== 32'h1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_stable: v %b imm %h tgt %h rdy %b want 1/00000001/00000001/0", out_valid, imm, target, in_ready); end
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b1 || imm !== 32'h2 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: v %b imm %h rdy %b want 1/00000002/1", out_valid, imm, in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 3'b111, 32'hFFF00093, 32'h200);
    tick();
    n_checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || imm !== 32'h0 || target !== 32'h200) begin
      n_fail++; $display("FAIL illegal_111: v %b ill %b imm %h tgt %h want 1/1/0/200", out_valid, illegal, imm, target); end
    drive(1'b1, 3'b101, 32'h000F8000, 32'h300);
    tick();
`ifdef IMM_ZTYPE_EN
    n_checks++; if (illegal !== 1'b0 || imm !== 32'h1F || target !== 32'h31F) begin
      n_fail++; $display("FAIL ztype_en: ill %b imm %h tgt %h want 0/1f/31f", illegal, imm, target); end
`else
    n_checks++; if (illegal !== 1'b1 || imm !== 32'h0 || target !== 32'h300) begin
      n_fail++; $display("FAIL ztype_dis: ill %b imm %h tgt %h want 1/0/300", illegal, imm, target); end
`endif
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_xlen64();
    w_in_valid = 1'b1; w_imm_sel = 3'b100; w_instr = 25'(32'h800000B7 >> 7); w_pc = 64'h0;
    tick();
    n_checks++; if (w_out_valid !== 1'b1 || w_imm !== 64'hFFFF_FFFF_8000_0000) begin
      n_fail++; $display("FAIL x64_u: v %b imm %h want 1/ffffffff80000000", w_out_valid, w_imm); end
    w_imm_sel = 3'b000; w_instr = 25'(32'h00800093 >> 7); w_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    n_checks++; if (w_imm !== 64'h8 || w_target !== 64'h4) begin
      n_fail++; $display("FAIL x64_wrap: imm %h tgt %h want 8/4", w_imm, w_target); end
    w_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h00500093, 32'h0);
    tick();
    drive(1'b1, 3'b000, 32'h00600093, 32'h0);
    tick();
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_full: rdy %b v %b want 0/1", in_ready, out_valid); end
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: v %b rdy %b want 0/1", out_valid, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: v %b imm %h want 0", i, out_valid, imm); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_xlen64();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
